pattern_gen_p: RTL and testbench
================================

PATTERN_GEN_P -- requirements
Module: pattern_gen_p

Interface
REQ-001 SHALL have parameter PAT_W, default 10, pattern word width.
REQ-002 SHALL have parameter NUM_ROWS, default 160, sensor rows per subscene.
REQ-003 SHALL have parameter WORDS_PER_ROW, default 18, FIFO words per row; subscene length L = NUM_ROWS*WORDS_PER_ROW (default 2880).
REQ-004 SHALL have parameter CNT_W, default 32, width of count inputs.
REQ-005 SHALL have ports: clk in 1 (sole clock, posedge); rst in 1 (synchronous, active-low).
REQ-006 SHALL have ports: start in 1 (begin frame); abort in 1 (synchronous abort); continuous in 1 (loop frames).
REQ-007 SHALL have ports: Pat_in, PatGen_start, PatGen_stop in PAT_W (exposed, leading-blank and trailing-blank patterns).
REQ-008 SHALL have ports: Num_Pat, Mask_change_subc, Mask_change_no in CNT_W; mode in 2 (00 hold, 01 invert, 10 rotate-left-1, 11 hold).
REQ-009 SHALL have ports: FIFO_empty in 1; FIFO_full in 1; FIFO_wr out 1; Pat_out out PAT_W; busy out 1; frame_done out 1; CntSubc out CNT_W.

Function
REQ-010 SHALL implement states IDLE, FIRST, WAIT_EMPTY, PATS, LAST; every unreachable encoding SHALL go to IDLE on the next cycle.
REQ-011 SHALL have IDLE -> FIRST on start=1; load Pat_out=PatGen_start; clear word counter, CntSubc and change counters.
REQ-012 SHALL in FIRST, PATS and LAST drive FIFO_wr = ~FIFO_full (combinational from registered state); SHALL advance the word counter only on cycles with FIFO_wr=1; SHALL hold Pat_out constant within a subscene.
REQ-013 SHALL leave a write state after exactly L words have been written; no word SHALL be written while FIFO_full=1.
REQ-014 SHALL on FIRST done: latch Pat_out=Pat_in; if Num_Pat=0 then go to LAST with Pat_out=PatGen_stop, else go to WAIT_EMPTY.
REQ-015 SHALL in WAIT_EMPTY hold FIFO_wr=0 until FIFO_empty=1, then enter PATS on the next cycle.
REQ-016 SHALL on PATS done: increment CntSubc; apply mask-change rule (REQ-017); if CntSubc (new) = Num_Pat then go to LAST with Pat_out=PatGen_stop, else go to WAIT_EMPTY.
REQ-017 SHALL keep subscenes-since-change counter sc and changes-done counter nc; at PATS done, if Mask_change_subc!=0, sc+1=Mask_change_subc and nc<Mask_change_no: Pat_out <= op(mode, Pat_out), sc<=0, nc<=nc+1; otherwise sc<=sc+1 (saturating).
REQ-018 SHALL define invert as bitwise NOT and rotate-left-1 as {Pat[PAT_W-2:0],Pat[PAT_W-1]}.
REQ-019 SHALL on LAST done pulse frame_done=1 for one cycle; if continuous=1 go to FIRST with Pat_out=PatGen_start and clear counters, else go to IDLE.
REQ-020 SHALL hold busy=1 in every state except IDLE.
REQ-021 SHALL sample Pat_in, Num_Pat, mode and Mask_change_* only at the transitions named above; changes at other times SHALL have no effect until the next such sample.
REQ-022 SHALL treat abort=1 in any state as: next state IDLE, FIFO_wr=0 in that cycle, no frame_done; abort SHALL take priority over start.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL size the word counter to clog2(L+1) bits; sc, nc and CntSubc SHALL be CNT_W bits.

Reset
REQ-025 SHALL, with rst=0 at a clk edge, set: state IDLE; FIFO_wr=0; Pat_out=0; busy=0; frame_done=0; CntSubc=0; all internal counters 0.
REQ-026 SHALL treat reset mid-subscene identically to REQ-025, with no further FIFO writes until a new start.

Structure
REQ-027 SHALL place the state encoding and mode encodings (MODE_HOLD, MODE_INV, MODE_ROT) in shared package pattern_gen_pkg.
REQ-028 SHALL implement the sc/nc mask-change scheduler as sub-module mask_sched (inputs: subscene-done strobe, Mask_change_subc, Mask_change_no, clear; output: apply-change strobe).

Verification
REQ-029 SHALL cover: default params, Pat_in=0x155, Num_Pat=2, FIFO never full, FIFO_empty pulsed -> 2880 words of PatGen_start, 2x2880 of 0x155, 2880 of PatGen_stop, one frame_done, return to IDLE.
REQ-030 SHALL cover: mode=01, Mask_change_subc=1, Mask_change_no=2, Num_Pat=4 -> subscene patterns 0x155, 0x2AA, 0x155, 0x155.
REQ-031 SHALL cover: FIFO_full toggled randomly in PATS -> exactly 2880 writes per subscene, zero writes while FIFO_full=1.
REQ-032 SHALL cover: Num_Pat=0 -> FIRST directly followed by LAST, CntSubc=0, frame_done once.
REQ-033 SHALL cover: abort or rst=0 at word 1000 of PATS -> FIFO_wr=0 next cycle, IDLE, no frame_done; a new start runs a clean frame.
REQ-034 SHALL cover: continuous=1, mode=10, PAT_W=8, Pat_in=0x81, Mask_change_subc=1, Num_Pat=2 -> patterns 0x81, 0x03, then FIRST restarts with 0x81.

Source files
------------

// File: rtl/pattern_gen_pkg.sv
// Shared definitions for the pattern generator: FSM state encoding and the
// per-subscene pattern modification modes.
package pattern_gen_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFirst     = 3'd1,
    StWaitEmpty = 3'd2,
    StPats      = 3'd3,
    StLast      = 3'd4
  } state_e;

  // mode 2'b11 behaves as hold
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_ROT  = 2'b10;

endpackage

// File: rtl/pattern_gen_p_if.sv
// FIFO-side bus of the pattern generator.
//   FIFO_empty, FIFO_full : FIFO status towards the generator
//   FIFO_wr               : write strobe, one word per cycle when high
//   Pat_out               : pattern word written on FIFO_wr
// master = generator side, slave = FIFO side.
interface pattern_gen_p_if
  import pattern_gen_pkg::*;
#(
  parameter int unsigned PAT_W = 10
) ();

  logic             FIFO_empty;
  logic             FIFO_full;
  logic             FIFO_wr;
  logic [PAT_W-1:0] Pat_out;

  modport master (
    input  FIFO_empty,
    input  FIFO_full,
    output FIFO_wr,
    output Pat_out
  );

  modport slave (
    output FIFO_empty,
    output FIFO_full,
    input  FIFO_wr,
    input  Pat_out
  );

endinterface

// File: rtl/mask_sched.sv
// Mask-change scheduler. Counts subscenes since the last pattern change (sc)
// and changes done so far (nc); flags the subscene completion that should
// change the pattern.
//   clk, rst         : clock, synchronous active-low reset
//   subc_done        : strobe, one exposed subscene finished
//   clear            : strobe, zero both counters (frame start)
//   mask_change_subc : subscenes between changes (0 disables changes)
//   mask_change_no   : maximum number of changes per frame
//   apply_change     : combinational, valid together with subc_done
module mask_sched
  import pattern_gen_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             subc_done,
  input  logic             clear,
  input  logic [CNT_W-1:0] mask_change_subc,
  input  logic [CNT_W-1:0] mask_change_no,
  output logic             apply_change
);

  logic [CNT_W-1:0] sc_q, sc_d;
  logic [CNT_W-1:0] nc_q, nc_d;
  logic [CNT_W:0]   sc_inc;

  // One extra bit so a saturated sc never wraps onto a match.
  assign sc_inc = {1'b0, sc_q} + (CNT_W + 1)'(1);

  assign apply_change = subc_done && (mask_change_subc != '0) &&
                        (sc_inc == {1'b0, mask_change_subc}) && (nc_q < mask_change_no);

  always_comb begin
    sc_d = sc_q;
    nc_d = nc_q;
    if (clear) begin
      sc_d = '0;
      nc_d = '0;
    end else if (subc_done) begin
      if (apply_change) begin
        sc_d = '0;
        nc_d = nc_q + CNT_W'(1);
      end else if (sc_q != '1) begin
        sc_d = sc_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sc_q <= '0;
      nc_q <= '0;
    end else begin
      sc_q <= sc_d;
      nc_q <= nc_d;
    end
  end

endmodule

// File: rtl/pattern_gen_p.sv
// Frame pattern generator. A frame is one leading-blank subscene
// (PatGen_start), Num_Pat exposed subscenes (Pat_in, optionally modified every
// Mask_change_subc subscenes) and one trailing-blank subscene (PatGen_stop).
// Each subscene is NUM_ROWS*WORDS_PER_ROW FIFO words of one constant pattern.
//   clk, rst                      : clock, synchronous active-low reset
//   start, abort, continuous      : frame control
//   Pat_in, PatGen_start/stop     : exposed / leading / trailing patterns
//   Num_Pat                       : exposed subscenes per frame
//   Mask_change_subc/no, mode     : pattern change schedule and operation
//   fifo                          : FIFO bus (status in, FIFO_wr/Pat_out out)
//   busy, frame_done, CntSubc     : status outputs
module pattern_gen_p
  import pattern_gen_pkg::*;
#(
  parameter int unsigned PAT_W         = 10,
  parameter int unsigned NUM_ROWS      = 160,
  parameter int unsigned WORDS_PER_ROW = 18,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   continuous,
  input  logic [PAT_W-1:0]       Pat_in,
  input  logic [PAT_W-1:0]       PatGen_start,
  input  logic [PAT_W-1:0]       PatGen_stop,
  input  logic [CNT_W-1:0]       Num_Pat,
  input  logic [CNT_W-1:0]       Mask_change_subc,
  input  logic [CNT_W-1:0]       Mask_change_no,
  input  logic [1:0]             mode,
  pattern_gen_p_if.master        fifo,
  output logic                   busy,
  output logic                   frame_done,
  output logic [CNT_W-1:0]       CntSubc
);

  localparam int unsigned SubLen = NUM_ROWS * WORDS_PER_ROW;
  localparam int unsigned WcntW  = $clog2(SubLen + 1);

  state_e             st_q, st_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [WcntW-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fd_q, fd_d;

  logic               write_st;
  logic               fifo_wr;
  logic               word_done;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_subc;
  logic               start_frame;
  logic               restart;
  logic               subc_done;
  logic               apply_change;

  function automatic logic [PAT_W-1:0] apply_mode(input logic [1:0]       m,
                                                   input logic [PAT_W-1:0] p);
    case (m)
      MODE_INV: return ~p;
      MODE_ROT: return {p[PAT_W-2:0], p[PAT_W-1]};
      default:  return p;
    endcase
  endfunction

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign last_subc   = (cnt_inc == Num_Pat);
  assign start_frame = (st_q == StIdle) && start && !abort;
  assign restart     = (st_q == StLast) && word_done && continuous;
  assign subc_done   = (st_q == StPats) && word_done;

  mask_sched #(
    .CNT_W (CNT_W)
  ) u_mask_sched (
    .clk              (clk),
    .rst              (rst),
    .subc_done        (subc_done),
    .clear            (start_frame || restart),
    .mask_change_subc (Mask_change_subc),
    .mask_change_no   (Mask_change_no),
    .apply_change     (apply_change)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q <= StIdle;
    end else begin
      st_q <= st_d;
    end
  end

  // Next-state logic
  always_comb begin
    st_d = st_q;
    case (st_q)
      StIdle:      if (start) st_d = StFirst;
      StFirst:     if (word_done) st_d = (Num_Pat == '0) ? StLast : StWaitEmpty;
      StWaitEmpty: if (fifo.FIFO_empty) st_d = StPats;
      StPats:      if (word_done) st_d = last_subc ? StLast : StWaitEmpty;
      StLast:      if (word_done) st_d = continuous ? StFirst : StIdle;
      default:     st_d = StIdle;
    endcase
    if (abort) st_d = StIdle;
  end

  // Outputs decoded from the registered state
  always_comb begin
    write_st = 1'b0;
    busy     = 1'b1;
    case (st_q)
      StIdle:                  busy     = 1'b0;
      StFirst, StPats, StLast: write_st = 1'b1;
      default:                 ;
    endcase
    // rst gating keeps a reset cycle from pushing a word the FSM never counts
    fifo_wr   = write_st && !fifo.FIFO_full && !abort && rst;
    word_done = fifo_wr && (wcnt_q == WcntW'(SubLen - 1));
  end

  assign fifo.FIFO_wr = fifo_wr;
  assign fifo.Pat_out = pat_q;
  assign frame_done   = fd_q;
  assign CntSubc      = cnt_q;

  // Datapath next-state
  always_comb begin
    pat_d  = pat_q;
    wcnt_d = wcnt_q;
    cnt_d  = cnt_q;
    fd_d   = 1'b0;
    if (abort) begin
      wcnt_d = '0;
    end else begin
      if (fifo_wr) wcnt_d = word_done ? '0 : wcnt_q + WcntW'(1);
      case (st_q)
        StIdle: begin
          if (start) begin
            pat_d  = PatGen_start;
            cnt_d  = '0;
            wcnt_d = '0;
          end
        end
        StFirst: begin
          if (word_done) pat_d = (Num_Pat == '0) ? PatGen_stop : Pat_in;
        end
        StPats: begin
          if (word_done) begin
            cnt_d = cnt_inc;
            if (last_subc)         pat_d = PatGen_stop;
            else if (apply_change) pat_d = apply_mode(mode, pat_q);
          end
        end
        StLast: begin
          if (word_done) begin
            fd_d = 1'b1;
            if (continuous) begin
              pat_d = PatGen_start;
              cnt_d = '0;
            end
          end
        end
        StWaitEmpty: ;
        default: wcnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q  <= '0;
      wcnt_q <= '0;
      cnt_q  <= '0;
      fd_q   <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      wcnt_q <= wcnt_d;
      cnt_q  <= cnt_d;
      fd_q   <= fd_d;
    end
  end

endmodule

// File: tb/tb_pattern_gen_p.sv
// Bench for pattern_gen_p: a default-parameter instance (a) and a small
// PAT_W=8, 6-word-subscene instance (b). Frame expectations are pushed as
// (pattern, word count) entries; per-instance monitors consume them on writes.
module tb_pattern_gen_p;

  localparam int unsigned LA = 2880;
  localparam int unsigned LB = 6;

  typedef struct {
    logic [9:0]  pat;
    int unsigned words;
  } sub_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance a stimulus / outputs
  logic        rst_a, start_a, abort_a, cont_a, busy_a, fd_sig_a;
  logic [9:0]  pin_a, pstart_a, pstop_a;
  logic [31:0] np_a, mcs_a, mcn_a, cnt_a;
  logic [1:0]  mode_a;
  // Instance b stimulus / outputs
  logic        rst_b, start_b, abort_b, cont_b, busy_b, fd_sig_b;
  logic [7:0]  pin_b, pstart_b, pstop_b;
  logic [31:0] np_b, mcs_b, mcn_b, cnt_b;
  logic [1:0]  mode_b;

  bit full_en_a = 1'b0;
  bit full_en_b = 1'b0;

  pattern_gen_p_if #(.PAT_W(10)) fa ();
  pattern_gen_p_if #(.PAT_W(8))  fb ();

  pattern_gen_p #(
    .PAT_W(10), .NUM_ROWS(160), .WORDS_PER_ROW(18), .CNT_W(32)
  ) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .abort(abort_a), .continuous(cont_a),
    .Pat_in(pin_a), .PatGen_start(pstart_a), .PatGen_stop(pstop_a),
    .Num_Pat(np_a), .Mask_change_subc(mcs_a), .Mask_change_no(mcn_a), .mode(mode_a),
    .fifo(fa), .busy(busy_a), .frame_done(fd_sig_a), .CntSubc(cnt_a)
  );

  pattern_gen_p #(
    .PAT_W(8), .NUM_ROWS(2), .WORDS_PER_ROW(3), .CNT_W(32)
  ) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .abort(abort_b), .continuous(cont_b),
    .Pat_in(pin_b), .PatGen_start(pstart_b), .PatGen_stop(pstop_b),
    .Num_Pat(np_b), .Mask_change_subc(mcs_b), .Mask_change_no(mcn_b), .mode(mode_b),
    .fifo(fb), .busy(busy_b), .frame_done(fd_sig_b), .CntSubc(cnt_b)
  );

  // Scoreboard state
  sub_t exp_a[$];
  sub_t exp_b[$];
  int wr_a = 0, wrfull_a = 0, extra_a = 0, done_a = 0, bad_a = 0, fdc_a = 0;
  int wr_b = 0, wrfull_b = 0, extra_b = 0, done_b = 0, bad_b = 0, fdc_b = 0;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Reference model: subscene k (1-based) is followed by a change when it is a
  // multiple of msub and at most mno changes have happened.
  task automatic push_frame(input bit sel, input int unsigned w, input int unsigned l,
                            input logic [9:0] ps, input logic [9:0] pi, input logic [9:0] pe,
                            input int unsigned n, input logic [1:0] m,
                            input int unsigned msub, input int unsigned mno);
    int unsigned mask = (1 << w) - 1;
    int unsigned p    = int'(pi);
    sub_t e;
    e.words = l;
    e.pat = ps;
    if (sel) exp_b.push_back(e); else exp_a.push_back(e);
    for (int k = 1; k <= int'(n); k++) begin
      e.pat = 10'(p);
      if (sel) exp_b.push_back(e); else exp_a.push_back(e);
      if (msub != 0 && (k % msub) == 0 && (k / msub) <= mno) begin
        if (m == 2'b01)      p = (~p) & mask;
        else if (m == 2'b10) p = ((p << 1) | (p >> (w - 1))) & mask;
      end
    end
    e.pat = pe;
    if (sel) exp_b.push_back(e); else exp_a.push_back(e);
  endtask

  task automatic flush(input bit sel);
    if (sel) begin
      exp_b.delete(); done_b = 0; bad_b = 0;
    end else begin
      exp_a.delete(); done_a = 0; bad_a = 0;
    end
  endtask

  // Monitors: sample on the falling edge, between input updates and capture.
  initial forever begin
    @(negedge clk);
    if (fa.FIFO_wr) begin
      wr_a++;
      if (fa.FIFO_full) wrfull_a++;
      if (exp_a.size() == 0) extra_a++;
      else begin
        if (fa.Pat_out != exp_a[0].pat) bad_a++;
        done_a++;
        if (done_a == int'(exp_a[0].words)) begin
          check($sformatf("subscene_bad_words_a(pat 0x%0h)", exp_a[0].pat), bad_a, 0);
          void'(exp_a.pop_front());
          done_a = 0;
          bad_a  = 0;
        end
      end
    end
    if (fd_sig_a) fdc_a++;
  end

  initial forever begin
    @(negedge clk);
    if (fb.FIFO_wr) begin
      wr_b++;
      if (fb.FIFO_full) wrfull_b++;
      if (exp_b.size() == 0) extra_b++;
      else begin
        if (10'(fb.Pat_out) != exp_b[0].pat) bad_b++;
        done_b++;
        if (done_b == int'(exp_b[0].words)) begin
          check($sformatf("subscene_bad_words_b(pat 0x%0h)", exp_b[0].pat), bad_b, 0);
          void'(exp_b.pop_front());
          done_b = 0;
          bad_b  = 0;
        end
      end
    end
    if (fd_sig_b) fdc_b++;
  end

  // FIFO status drivers: empty pulses randomly, full toggles randomly when enabled.
  initial forever begin
    @(posedge clk);
    #1;
    fa.FIFO_empty = ($urandom_range(0, 3) == 0);
    fb.FIFO_empty = ($urandom_range(0, 3) == 0);
    fa.FIFO_full  = full_en_a && ($urandom_range(0, 1) == 1);
    fb.FIFO_full  = full_en_b && ($urandom_range(0, 1) == 1);
  end

  function automatic int get_fdc(input bit sel);
    return sel ? fdc_b : fdc_a;
  endfunction

  function automatic int get_wr(input bit sel);
    return sel ? wr_b : wr_a;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic frame_begin(input bit sel, input logic [9:0] ps, input logic [9:0] pi,
                             input logic [9:0] pe, input int unsigned n, input logic [1:0] m,
                             input int unsigned msub, input int unsigned mno,
                             input bit full_en);
    if (sel) begin
      pstart_b = ps[7:0]; pin_b = pi[7:0]; pstop_b = pe[7:0];
      np_b = n; mode_b = m; mcs_b = msub; mcn_b = mno; full_en_b = full_en;
      wr_b = 0; wrfull_b = 0; extra_b = 0; fdc_b = 0;
    end else begin
      pstart_a = ps; pin_a = pi; pstop_a = pe;
      np_a = n; mode_a = m; mcs_a = msub; mcn_a = mno; full_en_a = full_en;
      wr_a = 0; wrfull_a = 0; extra_a = 0; fdc_a = 0;
    end
    push_frame(sel, sel ? 8 : 10, sel ? LB : LA, ps, pi, pe, n, m, msub, mno);
    cycle();
    set_start(sel, 1'b1);
    cycle();
    set_start(sel, 1'b0);
    // A stray start while busy must not disturb the frame.
    cycle();
    cycle();
    set_start(sel, 1'b1);
    cycle();
    set_start(sel, 1'b0);
  endtask

  task automatic wait_fd(input bit sel, input int target, input int budget);
    int k = 0;
    while (get_fdc(sel) < target && k < budget) begin
      cycle();
      k++;
    end
  endtask

  task automatic frame_end(input bit sel, input int unsigned n, input int frames);
    int unsigned l = sel ? LB : LA;
    string s = sel ? "_b" : "_a";
    wait_fd(sel, frames, frames * int'(4 * l * (n + 2) + 50 * (n + 2)) + 200);
    repeat (3) cycle();
    check({"frame_done_count", s}, get_fdc(sel), frames);
    check({"subscenes_left", s}, sel ? exp_b.size() : exp_a.size(), 0);
    check({"words_written", s}, get_wr(sel), frames * int'(l * (n + 2)));
    check({"writes_while_full", s}, sel ? wrfull_b : wrfull_a, 0);
    check({"unexpected_writes", s}, sel ? extra_b : extra_a, 0);
    check({"busy_after_frame", s}, sel ? busy_b : busy_a, 0);
    check({"cnt_subc", s}, sel ? cnt_b : cnt_a, n);
    if (sel) full_en_b = 1'b0; else full_en_a = 1'b0;
    flush(sel);
  endtask

  task automatic frame(input bit sel, input logic [9:0] ps, input logic [9:0] pi,
                       input logic [9:0] pe, input int unsigned n, input logic [1:0] m,
                       input int unsigned msub, input int unsigned mno, input bit full_en);
    frame_begin(sel, ps, pi, pe, n, m, msub, mno, full_en);
    frame_end(sel, n, 1);
  endtask

  task automatic wait_writes(input bit sel, input int target);
    int k = 0;
    while (get_wr(sel) < target && k < 4 * target + 200) begin
      cycle();
      k++;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    {rst_a, start_a, abort_a, cont_a} = '0;
    {rst_b, start_b, abort_b, cont_b} = '0;
    {pin_a, pstart_a, pstop_a, np_a, mcs_a, mcn_a, mode_a} = '0;
    {pin_b, pstart_b, pstop_b, np_b, mcs_b, mcn_b, mode_b} = '0;
    fa.FIFO_empty = 1'b0; fa.FIFO_full = 1'b0;
    fb.FIFO_empty = 1'b0; fb.FIFO_full = 1'b0;
    repeat (3) cycle();

    // Reset state
    check("rst_busy_a", busy_a, 0);
    check("rst_fifo_wr_a", fa.FIFO_wr, 0);
    check("rst_pat_out_a", fa.Pat_out, 0);
    check("rst_frame_done_a", fd_sig_a, 0);
    check("rst_cnt_subc_a", cnt_a, 0);
    check("rst_busy_b", busy_b, 0);
    check("rst_pat_out_b", fb.Pat_out, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    cycle();

    // Plain frame: start, 2 x 0x155, stop
    frame(0, 10'h3C3, 10'h155, 10'h0F0, 2, 2'b00, 0, 0, 0);
    // Invert every subscene, two changes: 0x155, 0x2AA, 0x155, 0x155
    frame(0, 10'h3C3, 10'h155, 10'h0F0, 4, 2'b01, 1, 2, 0);
    // FIFO_full toggling throughout
    frame(0, 10'h3C3, 10'h155, 10'h0F0, 1, 2'b10, 0, 0, 1);

    // Abort at word 1000 of the first exposed subscene
    frame_begin(0, 10'h3C3, 10'h155, 10'h0F0, 2, 2'b00, 0, 0, 0);
    wait_writes(0, LA + 1000);
    check("abort_reach_word", wr_a, LA + 1000);
    abort_a = 1'b1;
    @(negedge clk);
    check("abort_fifo_wr", fa.FIFO_wr, 0);
    cycle();
    abort_a = 1'b0;
    check("abort_busy", busy_a, 0);
    flush(0);
    repeat (5) cycle();
    check("abort_no_more_writes", wr_a, LA + 1000);
    check("abort_no_frame_done", fdc_a, 0);
    // Clean frame after abort, no exposed subscenes
    frame(0, 10'h2A5, 10'h155, 10'h01F, 0, 2'b00, 0, 0, 0);

    // Continuous, rotate: 0x81, 0x03, then FIRST again with 0x81
    cont_b = 1'b1;
    frame_begin(1, 10'h081, 10'h081, 10'h03C, 2, 2'b10, 1, 1, 0);
    push_frame(1, 8, LB, 10'h081, 10'h081, 10'h03C, 2, 2'b10, 1, 1);
    wait_fd(1, 1, 400);
    check("cont_first_frame_done", fdc_b, 1);
    check("cont_restart_pat", fb.Pat_out, 8'h81);
    check("cont_restart_busy", busy_b, 1);
    check("cont_cnt_cleared", cnt_b, 0);
    cont_b = 1'b0;
    frame_end(1, 2, 2);

    // Reset in the middle of an exposed subscene
    frame_begin(1, 10'h0A5, 10'h05A, 10'h0C3, 3, 2'b01, 1, 3, 0);
    wait_writes(1, LB + 3);
    check("rst_mid_reach_word", wr_b, LB + 3);
    rst_b = 1'b0;
    @(negedge clk);
    check("rst_mid_fifo_wr", fb.FIFO_wr, 0);
    cycle();
    rst_b = 1'b1;
    check("rst_mid_busy", busy_b, 0);
    check("rst_mid_pat_out", fb.Pat_out, 0);
    check("rst_mid_cnt_subc", cnt_b, 0);
    flush(1);
    repeat (5) cycle();
    check("rst_mid_no_more_writes", wr_b, LB + 3);
    check("rst_mid_no_frame_done", fdc_b, 0);
    frame(1, 10'h0A5, 10'h05A, 10'h0C3, 2, 2'b01, 1, 3, 0);

    // Randomized frames on the small instance
    for (int i = 0; i < 40; i++) begin
      frame(1, 10'($urandom_range(0, 255)), 10'($urandom_range(0, 255)),
            10'($urandom_range(0, 255)), $urandom_range(0, 5), 2'($urandom_range(0, 3)),
            $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
